// File: rtl/res_tbl_update_ctrl.sv
// res_tbl_update_ctrl: sequences alloc/dealloc requests into resource_table_group one at a
// time and returns the captured largest-free-space results to the allocator.
// Optional feature macro: RES_TBL_TIMEOUT_EN (WAIT_DONE watchdog with sticky err_timeout_o).
module res_tbl_update_ctrl #(
  parameter int NUMBER_CU             = 2,
  parameter int CU_ID_WIDTH           = 1,
  parameter int TIMEOUT_CYCLES        = 64,
  parameter int WG_ID_WIDTH           = 6,
  parameter int LDS_ID_WIDTH          = 8,
  parameter int VGPR_ID_WIDTH         = 8,
  parameter int SGPR_ID_WIDTH         = 7,
  parameter int WF_COUNT_WIDTH_PER_WG = 4,
  parameter int WF_COUNT_WIDTH        = 6,
  parameter int WG_COUNT_WIDTH        = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_valid_i,
  output logic                             alloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]           alloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]           alloc_cu_id_i,
  input  logic [LDS_ID_WIDTH-1:0]          alloc_lds_start_i,
  input  logic [LDS_ID_WIDTH:0]            alloc_lds_size_i,
  input  logic [VGPR_ID_WIDTH-1:0]         alloc_vgpr_start_i,
  input  logic [VGPR_ID_WIDTH:0]           alloc_vgpr_size_i,
  input  logic [SGPR_ID_WIDTH-1:0]         alloc_sgpr_start_i,
  input  logic [SGPR_ID_WIDTH:0]           alloc_sgpr_size_i,
  input  logic [WF_COUNT_WIDTH_PER_WG-1:0] alloc_wf_count_i,
  input  logic                             dealloc_valid_i,
  output logic                             dealloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]           dealloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]           dealloc_cu_id_i,
  output logic                             alloc_en_o,
  output logic                             dealloc_en_o,
  output logic [WG_ID_WIDTH-1:0]           wg_id_o,
  output logic [CU_ID_WIDTH-1:0]           sub_cu_id_o,
  output logic [LDS_ID_WIDTH-1:0]          lds_start_o,
  output logic [LDS_ID_WIDTH:0]            lds_size_o,
  output logic [VGPR_ID_WIDTH-1:0]         vgpr_start_o,
  output logic [VGPR_ID_WIDTH:0]           vgpr_size_o,
  output logic [SGPR_ID_WIDTH-1:0]         sgpr_start_o,
  output logic [SGPR_ID_WIDTH:0]           sgpr_size_o,
  output logic [WF_COUNT_WIDTH_PER_WG-1:0] wf_count_o,
  output logic                             done_cancelled_o,
  input  logic                             res_tbl_done_i,
  input  logic [LDS_ID_WIDTH-1:0]          res_lds_start_i,
  input  logic [LDS_ID_WIDTH:0]            res_lds_size_i,
  input  logic [VGPR_ID_WIDTH-1:0]         res_vgpr_start_i,
  input  logic [VGPR_ID_WIDTH:0]           res_vgpr_size_i,
  input  logic [SGPR_ID_WIDTH-1:0]         res_sgpr_start_i,
  input  logic [SGPR_ID_WIDTH:0]           res_sgpr_size_i,
  input  logic [WF_COUNT_WIDTH-1:0]        res_wf_count_i,
  input  logic [WG_COUNT_WIDTH-1:0]        res_wg_count_i,
  output logic                             upd_valid_o,
  input  logic                             upd_ready_i,
  output logic [CU_ID_WIDTH-1:0]           upd_cu_id_o,
  output logic [LDS_ID_WIDTH-1:0]          upd_lds_start_o,
  output logic [LDS_ID_WIDTH:0]            upd_lds_size_o,
  output logic [VGPR_ID_WIDTH-1:0]         upd_vgpr_start_o,
  output logic [VGPR_ID_WIDTH:0]           upd_vgpr_size_o,
  output logic [SGPR_ID_WIDTH-1:0]         upd_sgpr_start_o,
  output logic [SGPR_ID_WIDTH:0]           upd_sgpr_size_o,
  output logic [WF_COUNT_WIDTH-1:0]        upd_wf_count_o,
  output logic [WG_COUNT_WIDTH-1:0]        upd_wg_count_o,
  output logic                             busy_o,
  output logic                             err_timeout_o
);

  if (TIMEOUT_CYCLES < 2 || NUMBER_CU < 1) begin : g_bad_cfg
    $error("res_tbl_update_ctrl: NUMBER_CU must be >=1 and TIMEOUT_CYCLES >=2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_UPDATE, S_CANCEL
  } state_t;

  state_t state, state_nxt;
  logic   op_dealloc;     // kind of the last accepted op; also the arbitration history bit
  logic   wait_first;     // first WAIT_DONE cycle, where a stale done is ignored
  logic   pick_dealloc, accept_alloc, accept_dealloc, capture;
`ifdef RES_TBL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             err_q;
`endif

  // Arbitration: dealloc wins a tie unless the previous op was dealloc.
  always_comb begin
    pick_dealloc   = dealloc_valid_i & (~alloc_valid_i | ~op_dealloc);
    accept_alloc   = (state == S_IDLE) & alloc_valid_i & ~pick_dealloc;
    accept_dealloc = (state == S_IDLE) & pick_dealloc;
    alloc_ready_o  = accept_alloc;
    dealloc_ready_o = accept_dealloc;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
`ifdef RES_TBL_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      S_IDLE:      if (accept_alloc | accept_dealloc) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!wait_first && res_tbl_done_i) begin
          capture   = 1'b1;
          state_nxt = S_UPDATE;
        end
`ifdef RES_TBL_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_CANCEL;
        end
`endif
      end
      S_UPDATE:    if (upd_ready_i) state_nxt = S_CANCEL;
      S_CANCEL:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register and op bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_dealloc <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_first <= (state == S_ISSUE);
      if (accept_alloc | accept_dealloc) op_dealloc <= accept_dealloc;
    end
  end

  // Command fields, loaded on accept and held for the whole op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wg_id_o      <= '0;
      sub_cu_id_o  <= '0;
      lds_start_o  <= '0;
      lds_size_o   <= '0;
      vgpr_start_o <= '0;
      vgpr_size_o  <= '0;
      sgpr_start_o <= '0;
      sgpr_size_o  <= '0;
      wf_count_o   <= '0;
    end else if (accept_alloc) begin
      wg_id_o      <= alloc_wg_id_i;
      sub_cu_id_o  <= alloc_cu_id_i;
      lds_start_o  <= alloc_lds_start_i;
      lds_size_o   <= alloc_lds_size_i;
      vgpr_start_o <= alloc_vgpr_start_i;
      vgpr_size_o  <= alloc_vgpr_size_i;
      sgpr_start_o <= alloc_sgpr_start_i;
      sgpr_size_o  <= alloc_sgpr_size_i;
      wf_count_o   <= alloc_wf_count_i;
    end else if (accept_dealloc) begin
      wg_id_o      <= dealloc_wg_id_i;
      sub_cu_id_o  <= dealloc_cu_id_i;
      lds_start_o  <= '0;
      lds_size_o   <= '0;
      vgpr_start_o <= '0;
      vgpr_size_o  <= '0;
      sgpr_start_o <= '0;
      sgpr_size_o  <= '0;
      wf_count_o   <= '0;
    end
  end

  // Result capture on the accepted done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_cu_id_o      <= '0;
      upd_lds_start_o  <= '0;
      upd_lds_size_o   <= '0;
      upd_vgpr_start_o <= '0;
      upd_vgpr_size_o  <= '0;
      upd_sgpr_start_o <= '0;
      upd_sgpr_size_o  <= '0;
      upd_wf_count_o   <= '0;
      upd_wg_count_o   <= '0;
    end else if (capture) begin
      upd_cu_id_o      <= sub_cu_id_o;
      upd_lds_start_o  <= res_lds_start_i;
      upd_lds_size_o   <= res_lds_size_i;
      upd_vgpr_start_o <= res_vgpr_start_i;
      upd_vgpr_size_o  <= res_vgpr_size_i;
      upd_sgpr_start_o <= res_sgpr_start_i;
      upd_sgpr_size_o  <= res_sgpr_size_i;
      upd_wf_count_o   <= res_wf_count_i;
      upd_wg_count_o   <= res_wg_count_i;
    end
  end

`ifdef RES_TBL_TIMEOUT_EN
  // WAIT_DONE watchdog: counter restarts on entry, error flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_ISSUE)          wait_cnt <= '0;
      else if (state == S_WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)               err_q    <= 1'b1;
    end
  end
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign alloc_en_o       = (state == S_ISSUE) & ~op_dealloc;
  assign dealloc_en_o     = (state == S_ISSUE) &  op_dealloc;
  assign upd_valid_o      = (state == S_UPDATE);
  assign done_cancelled_o = (state == S_CANCEL);
  assign busy_o           = (state != S_IDLE);

endmodule

// File: tb/tb_res_tbl_update_ctrl.sv
// Directed bench for res_tbl_update_ctrl; covers RES_TBL_TIMEOUT_EN when defined.
module tb_res_tbl_update_ctrl;
  localparam int CUW = 1, WGW = 6, LDSW = 8, VGPRW = 8, SGPRW = 7, WFPW = 4, WFW = 6, WGCW = 5;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready, dealloc_valid, dealloc_ready;
  logic [WGW-1:0] alloc_wg, dealloc_wg, wg_id;
  logic [CUW-1:0] alloc_cu, dealloc_cu, sub_cu, upd_cu;
  logic [LDSW-1:0] a_ls, lds_start, r_ls, u_ls;
  logic [LDSW:0]   a_lz, lds_size, r_lz, u_lz;
  logic [VGPRW-1:0] a_vs, vgpr_start, r_vs, u_vs;
  logic [VGPRW:0]   a_vz, vgpr_size, r_vz, u_vz;
  logic [SGPRW-1:0] a_ss, sgpr_start, r_ss, u_ss;
  logic [SGPRW:0]   a_sz, sgpr_size, r_sz, u_sz;
  logic [WFPW-1:0]  a_wf, wf_count;
  logic [WFW-1:0]   r_wf, u_wf;
  logic [WGCW-1:0]  r_wg, u_wg;
  logic alloc_en, dealloc_en, done_cancelled, res_done, upd_valid, upd_ready, busy, err;

  typedef struct packed {
    logic [LDSW-1:0] ls; logic [LDSW:0] lz;
    logic [VGPRW-1:0] vs; logic [VGPRW:0] vz;
    logic [SGPRW-1:0] ss; logic [SGPRW:0] sz;
    logic [WFW-1:0] wf; logic [WGCW-1:0] wg;
  } res_t;
  res_t res_tab [4];

  int n_checks = 0;
  int n_errors = 0;

  res_tbl_update_ctrl #(
    .NUMBER_CU(2), .CU_ID_WIDTH(CUW), .TIMEOUT_CYCLES(8), .WG_ID_WIDTH(WGW),
    .LDS_ID_WIDTH(LDSW), .VGPR_ID_WIDTH(VGPRW), .SGPR_ID_WIDTH(SGPRW),
    .WF_COUNT_WIDTH_PER_WG(WFPW), .WF_COUNT_WIDTH(WFW), .WG_COUNT_WIDTH(WGCW)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_wg_id_i(alloc_wg), .alloc_cu_id_i(alloc_cu),
    .alloc_lds_start_i(a_ls), .alloc_lds_size_i(a_lz),
    .alloc_vgpr_start_i(a_vs), .alloc_vgpr_size_i(a_vz),
    .alloc_sgpr_start_i(a_ss), .alloc_sgpr_size_i(a_sz),
    .alloc_wf_count_i(a_wf),
    .dealloc_valid_i(dealloc_valid), .dealloc_ready_o(dealloc_ready),
    .dealloc_wg_id_i(dealloc_wg), .dealloc_cu_id_i(dealloc_cu),
    .alloc_en_o(alloc_en), .dealloc_en_o(dealloc_en),
    .wg_id_o(wg_id), .sub_cu_id_o(sub_cu),
    .lds_start_o(lds_start), .lds_size_o(lds_size),
    .vgpr_start_o(vgpr_start), .vgpr_size_o(vgpr_size),
    .sgpr_start_o(sgpr_start), .sgpr_size_o(sgpr_size),
    .wf_count_o(wf_count), .done_cancelled_o(done_cancelled),
    .res_tbl_done_i(res_done),
    .res_lds_start_i(r_ls), .res_lds_size_i(r_lz),
    .res_vgpr_start_i(r_vs), .res_vgpr_size_i(r_vz),
    .res_sgpr_start_i(r_ss), .res_sgpr_size_i(r_sz),
    .res_wf_count_i(r_wf), .res_wg_count_i(r_wg),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready),
    .upd_cu_id_o(upd_cu),
    .upd_lds_start_o(u_ls), .upd_lds_size_o(u_lz),
    .upd_vgpr_start_o(u_vs), .upd_vgpr_size_o(u_vz),
    .upd_sgpr_start_o(u_ss), .upd_sgpr_size_o(u_sz),
    .upd_wf_count_o(u_wf), .upd_wg_count_o(u_wg),
    .busy_o(busy), .err_timeout_o(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_res(input int k);
    r_ls = res_tab[k].ls; r_lz = res_tab[k].lz;
    r_vs = res_tab[k].vs; r_vz = res_tab[k].vz;
    r_ss = res_tab[k].ss; r_sz = res_tab[k].sz;
    r_wf = res_tab[k].wf; r_wg = res_tab[k].wg;
  endtask

  task automatic check_upd(input string tag, input int k, input logic [CUW-1:0] cu);
    check_eq({tag, "_valid"}, 32'(upd_valid), 1);
    check_eq({tag, "_cu"}, 32'(upd_cu), 32'(cu));
    check_eq({tag, "_lds_start"}, 32'(u_ls), 32'(res_tab[k].ls));
    check_eq({tag, "_lds_size"}, 32'(u_lz), 32'(res_tab[k].lz));
    check_eq({tag, "_vgpr_start"}, 32'(u_vs), 32'(res_tab[k].vs));
    check_eq({tag, "_vgpr_size"}, 32'(u_vz), 32'(res_tab[k].vz));
    check_eq({tag, "_sgpr_start"}, 32'(u_ss), 32'(res_tab[k].ss));
    check_eq({tag, "_sgpr_size"}, 32'(u_sz), 32'(res_tab[k].sz));
    check_eq({tag, "_wf"}, 32'(u_wf), 32'(res_tab[k].wf));
    check_eq({tag, "_wg"}, 32'(u_wg), 32'(res_tab[k].wg));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'({alloc_ready, dealloc_ready}), 0);
    check_eq({tag, "_en"}, 32'({alloc_en, dealloc_en}), 0);
    check_eq({tag, "_cmd_ids"}, 32'({wg_id, sub_cu}), 0);
    check_eq({tag, "_cmd_fields"}, 32'(lds_start | lds_size | vgpr_start | vgpr_size | sgpr_start | sgpr_size | wf_count), 0);
    check_eq({tag, "_ctl"}, 32'({done_cancelled, upd_valid, busy, err}), 0);
    check_eq({tag, "_upd_fields"}, 32'(upd_cu | u_ls | u_lz | u_vs | u_vz | u_ss | u_sz | u_wf | u_wg), 0);
  endtask

  // Runs an op from its ISSUE cycle to the following IDLE cycle; done asserted in the second WAIT cycle.
  task automatic complete_op(input string tag, input int k, input logic [CUW-1:0] cu, input int ready_delay);
    next_cycle();
    check_eq({tag, "_wait1_en"}, 32'({alloc_en, dealloc_en}), 0);
    next_cycle();
    drive_res(k);
    res_done = 1'b1;
    check_eq({tag, "_wait2_no_upd"}, 32'(upd_valid), 0);
    next_cycle();
    check_upd({tag, "_upd"}, k, cu);
    for (int i = 0; i < ready_delay; i++) begin
      next_cycle();
      check_upd({tag, "_hold"}, k, cu);
      check_eq({tag, "_hold_ready"}, 32'({alloc_ready, dealloc_ready}), 0);
    end
    upd_ready = 1'b1;
    next_cycle();
    upd_ready = 1'b0;
    check_eq({tag, "_cancel"}, 32'(done_cancelled), 1);
    check_eq({tag, "_cancel_no_upd"}, 32'(upd_valid), 0);
    check_eq({tag, "_cancel_ready"}, 32'({alloc_ready, dealloc_ready}), 0);
    res_done = 1'b0;
    next_cycle();
    check_eq({tag, "_idle_cancel"}, 32'(done_cancelled), 0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    res_tab[0] = '{ls: 8'd16, lz: 9'd100, vs: 8'd8,  vz: 9'd200, ss: 7'd4,  sz: 8'd60,  wf: 6'd30, wg: 5'd7};
    res_tab[1] = '{ls: 8'd1,  lz: 9'd2,   vs: 8'd3,  vz: 9'd4,   ss: 7'd5,  sz: 8'd6,   wf: 6'd7,  wg: 5'd8};
    res_tab[2] = '{ls: 8'd255, lz: 9'd256, vs: 8'd128, vz: 9'd300, ss: 7'd127, sz: 8'd128, wf: 6'd63, wg: 5'd31};
    res_tab[3] = '{ls: 8'd40, lz: 9'd41,  vs: 8'd42, vz: 9'd43,  ss: 7'd44, sz: 8'd45,  wf: 6'd46, wg: 5'd17};
    rst = 1'b1;
    alloc_valid = 1'b0; dealloc_valid = 1'b0; res_done = 1'b0; upd_ready = 1'b0;
    alloc_wg = '0; alloc_cu = '0; a_ls = '0; a_lz = '0; a_vs = '0; a_vz = '0;
    a_ss = '0; a_sz = '0; a_wf = '0; dealloc_wg = '0; dealloc_cu = '0;
    r_ls = '0; r_lz = '0; r_vs = '0; r_vz = '0; r_ss = '0; r_sz = '0; r_wf = '0; r_wg = '0;
    #3;
    check_all_zero("rst");
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // 1: lone alloc, done at t+4
    next_cycle();
    alloc_valid = 1'b1; alloc_cu = 1'b1; alloc_wg = 6'd5; a_vs = 8'd0; a_vz = 9'd8; a_wf = 4'd2;
    #1;
    check_eq("t1_alloc_ready", 32'(alloc_ready), 1);
    check_eq("t1_dealloc_ready", 32'(dealloc_ready), 0);
    next_cycle();
    alloc_valid = 1'b0;
    check_eq("t1_alloc_en", 32'(alloc_en), 1);
    check_eq("t1_dealloc_en", 32'(dealloc_en), 0);
    check_eq("t1_wg", 32'(wg_id), 5);
    check_eq("t1_cu", 32'(sub_cu), 1);
    check_eq("t1_vgpr", 32'({vgpr_start, vgpr_size}), 32'({8'd0, 9'd8}));
    check_eq("t1_wf", 32'(wf_count), 2);
    check_eq("t1_busy", 32'(busy), 1);
    next_cycle();
    check_eq("t1_en_single", 32'(alloc_en), 0);
    next_cycle();
    check_eq("t1_t3_no_upd", 32'(upd_valid), 0);
    next_cycle();
    drive_res(0);
    res_done = 1'b1;
    check_eq("t1_t4_no_upd", 32'(upd_valid), 0);
    check_eq("t1_wg_held", 32'(wg_id), 5);
    next_cycle();
    check_upd("t1_upd", 0, 1'b1);
    upd_ready = 1'b1;
    next_cycle();
    upd_ready = 1'b0;
    res_done = 1'b0;
    check_eq("t1_cancel", 32'(done_cancelled), 1);
    check_eq("t1_cancel_no_upd", 32'(upd_valid), 0);
    next_cycle();
    check_eq("t1_cancel_single", 32'(done_cancelled), 0);
    check_eq("t1_idle", 32'(busy), 0);

    // 2 and 3: tie arbitration from reset, then alternation; held update
    do_reset();
    alloc_valid = 1'b1; alloc_wg = 6'd10; alloc_cu = 1'b1;
    a_ls = 8'd3; a_lz = 9'd4; a_vs = 8'd1; a_vz = 9'd2; a_ss = 7'd5; a_sz = 8'd6; a_wf = 4'd3;
    dealloc_valid = 1'b1; dealloc_wg = 6'd20; dealloc_cu = 1'b0;
    #1;
    check_eq("t2_tie0_ready", 32'({alloc_ready, dealloc_ready}), 32'(2'b01));
    next_cycle();
    check_eq("t2_dealloc_en", 32'({alloc_en, dealloc_en}), 32'(2'b01));
    check_eq("t2_dealloc_wg", 32'(wg_id), 20);
    check_eq("t2_dealloc_cu", 32'(sub_cu), 0);
    check_eq("t2_dealloc_zero_fields", 32'(lds_start | lds_size | vgpr_start | vgpr_size | sgpr_start | sgpr_size | wf_count), 0);
    check_eq("t2_busy_ready", 32'({alloc_ready, dealloc_ready}), 0);
    complete_op("t2a", 1, 1'b0, 0);
    dealloc_wg = 6'd21;
    #1;
    check_eq("t2_tie1_ready", 32'({alloc_ready, dealloc_ready}), 32'(2'b10));
    next_cycle();
    check_eq("t2_alloc_en", 32'({alloc_en, dealloc_en}), 32'(2'b10));
    check_eq("t2_alloc_wg", 32'({wg_id, sub_cu}), 32'({6'd10, 1'b1}));
    check_eq("t2_alloc_lds", 32'({lds_start, lds_size}), 32'({8'd3, 9'd4}));
    check_eq("t2_alloc_vgpr", 32'({vgpr_start, vgpr_size}), 32'({8'd1, 9'd2}));
    check_eq("t2_alloc_sgpr", 32'({sgpr_start, sgpr_size}), 32'({7'd5, 8'd6}));
    check_eq("t2_alloc_wf", 32'(wf_count), 3);
    complete_op("t3", 2, 1'b1, 10);
    #1;
    check_eq("t2_tie2_ready", 32'({alloc_ready, dealloc_ready}), 32'(2'b01));
    next_cycle();
    alloc_valid = 1'b0; dealloc_valid = 1'b0;
    check_eq("t2_dealloc2_en", 32'({alloc_en, dealloc_en}), 32'(2'b01));
    check_eq("t2_dealloc2_wg", 32'(wg_id), 21);
    complete_op("t2c", 3, 1'b0, 0);

    // 4: done stuck high before issue; capture uses second WAIT cycle values
    drive_res(0);
    res_done = 1'b1;
    alloc_valid = 1'b1; alloc_wg = 6'd7; alloc_cu = 1'b0;
    next_cycle();
    alloc_valid = 1'b0;
    check_eq("t4_alloc_en", 32'(alloc_en), 1);
    next_cycle();
    drive_res(1);
    check_eq("t4_wait1_no_upd", 32'(upd_valid), 0);
    next_cycle();
    drive_res(3);
    check_eq("t4_wait2_no_upd", 32'(upd_valid), 0);
    next_cycle();
    check_upd("t4_upd", 3, 1'b0);
    upd_ready = 1'b1;
    next_cycle();
    upd_ready = 1'b0; res_done = 1'b0;
    check_eq("t4_cancel", 32'(done_cancelled), 1);
    next_cycle();
    check_eq("t4_idle", 32'(busy), 0);

    // 5: async reset in WAIT_DONE
    alloc_valid = 1'b1; alloc_wg = 6'd9; alloc_cu = 1'b1;
    next_cycle();
    alloc_valid = 1'b0;
    next_cycle();
    check_eq("t5_in_wait", 32'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_rst");
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check_eq("t5_no_en", 32'({alloc_en, dealloc_en, busy}), 0);
    next_cycle();
    check_eq("t5_no_en2", 32'({alloc_en, dealloc_en, busy}), 0);
    dealloc_valid = 1'b1;
    #1;
    check_eq("t5_ready_follows", 32'({alloc_ready, dealloc_ready}), 32'(2'b01));
    dealloc_valid = 1'b0;
    #1;
    check_eq("t5_ready_drops", 32'({alloc_ready, dealloc_ready}), 0);

    // 6: done never arrives
    next_cycle();
    alloc_valid = 1'b1; alloc_wg = 6'd33;
    next_cycle();
    alloc_valid = 1'b0;
    check_eq("t6_alloc_en", 32'(alloc_en), 1);
`ifdef RES_TBL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      check_eq("t6_wait_state", 32'({busy, err, upd_valid, done_cancelled}), 32'(4'b1000));
    end
    next_cycle();
    check_eq("t6_timeout_err", 32'(err), 1);
    check_eq("t6_timeout_cancel", 32'(done_cancelled), 1);
    check_eq("t6_timeout_no_upd", 32'(upd_valid), 0);
    next_cycle();
    check_eq("t6_sticky", 32'({busy, err, done_cancelled}), 32'(3'b010));
`else
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      check_eq("t6_wait_forever", 32'({busy, err, upd_valid, done_cancelled}), 32'(4'b1000));
    end
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
